cpu_core_param: RTL and testbench
=================================

# cpu_core_param

Parametrised multi-cycle successor of the lab 5 single-cycle CPU datapath. The register width and register count are set by parameters. Instruction fetch uses a request/acknowledge handshake, so memory may stall for any number of cycles, and conditional and unconditional branches are optional. It sits between the testbench/system instruction memory and nothing downstream; register contents are observable through a debug read port.

## Interface
- DATA_W, default 8: register and ALU width; allowed values 8..32.
- REG_AW, default 3: register address width; the file holds 2^REG_AW registers.
- PC_W, default 32: program counter width; byte address, always a multiple of 4.
- CLK  in  1: sole clock; all state updates on its rising edge.
- RESET  in  1: synchronous, active-low reset; sampled on CLK rising edge.
- PC  out  PC_W: registered address of the current/next fetch.
- IMEM_REQ  out  1: fetch request; combinational = (state==FETCH) && RESET.
- IMEM_ACK  in  1: memory has INSTRUCTION valid this cycle.
- INSTRUCTION  in  32: fetched word; sampled only when IMEM_REQ && IMEM_ACK.
- ZERO  out  1: registered flag, set when the last ALU result (add/sub/and/or) was 0.
- ILLEGAL  out  1: one-cycle registered pulse after an undefined opcode executes.
- DBG_ADDR  in  REG_AW: debug register select.
- DBG_DATA  out  DATA_W: combinational regs[DBG_ADDR].

## Operation
- Instruction format: [31:24] opcode, [23:16] dest (or branch offset), [15:8] src1, [7:0] src2 (or imm). Register fields use the low REG_AW bits.
- Opcodes:
  - 0x00 loadi: rd = sext(imm8).
  - 0x01 mov: rd = rs2.
  - 0x02 add: rd = rs1 + rs2.
  - 0x03 sub: rd = rs1 - rs2.
  - 0x04 and: rd = rs1 & rs2.
  - 0x05 or: rd = rs1 | rs2.
  - 0x06 j: PC = PC+4 + sext(off8)*4.
  - 0x07 beq: if rs1==rs2 then PC = PC+4 + sext(off8)*4, else PC+4.
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded. imm8 is sign-extended to DATA_W. The branch offset is sign-extended to PC_W, and the target wraps modulo 2^PC_W.
- Undefined opcodes: no register write and no ZERO update; PC+4; ILLEGAL=1 for the following cycle.
- Register 0 is an ordinary writable register. Reads of the destination within the same instruction see the old value.
- ZERO is updated only by add/sub/and/or; loadi, mov, j, beq and illegal opcodes leave it unchanged.
- Two-state FSM with internal IR register:
  - FETCH: IMEM_REQ=1. On an edge with IMEM_ACK=1, IR <= INSTRUCTION and go to EXEC. Otherwise stay, with all state held.
  - EXEC: decode IR, read registers, compute. On the edge: register write, ZERO/ILLEGAL update, PC <= next PC, go to FETCH.
- Reset values (any edge with RESET=0):
  - state=FETCH, PC=0, IR=0.
  - All registers 0, ZERO=0, ILLEGAL=0.
  - IMEM_REQ=0 while RESET=0.
  - Reset overrides everything: an in-flight fetch is abandoned and an EXEC instruction is not committed.

## Timing
- Minimum 2 cycles per instruction, with IMEM_ACK high in the FETCH cycle. Each FETCH cycle with IMEM_ACK=0 adds one cycle; there is no timeout.
- IMEM_REQ rises in the first cycle after RESET returns high and stays high until ACK is taken. It drops in EXEC for exactly one cycle.
- PC, register writes, ZERO and ILLEGAL change only on the EXEC→FETCH edge. IMEM_ACK during EXEC is ignored.
- DBG_DATA reflects a write immediately after the committing edge; it has no internal delay.
- ILLEGAL is high for exactly the FETCH cycle that follows the illegal EXEC, even if that FETCH stalls.

## Configuration
- CPU_BRANCH_EN defined: opcodes 0x06 (j) and 0x07 (beq) are implemented as above.
- CPU_BRANCH_EN undefined: no branch comparator or target adder is built. Opcodes 0x06 and 0x07 are treated as undefined: PC+4, ILLEGAL pulse, no state change.

## Test plan
- Reset: RESET=0 for 3 cycles with arbitrary INSTRUCTION/ACK -> PC=0, IMEM_REQ=0, all DBG_DATA=0, ZERO=0. Release -> IMEM_REQ=1 on the next cycle.
- ALU sequence (DATA_W=8, ACK tied 1): loadi r4,0x05; loadi r2,0x09; add r6,r4,r2; sub r5,r6,r4 -> r6=0x0E, r5=0x09, ZERO=0, PC=16 after 8 cycles.
- Stall: hold IMEM_ACK=0 for 5 cycles at PC=8 -> IMEM_REQ stays 1; PC, registers and ZERO are unchanged. ACK=1 -> the instruction commits 2 cycles later.
- Branch (CPU_BRANCH_EN): r1=r2=3; beq r1,r2,+2 at PC=8 -> PC=20; j -3 at PC=20 -> PC=12; sub r3,r1,r2 -> r3=0, ZERO=1.
- Illegal and reset: opcode 0xFF at PC=4 -> ILLEGAL pulses 1 cycle, no register change, PC=8. RESET=0 during the EXEC of add r6,... -> r6 is not written and PC=0. Rebuilt without CPU_BRANCH_EN, opcode 0x06 -> ILLEGAL pulse, PC+4.
- Width (DATA_W=16, REG_AW=4): loadi r15,0x80 -> r15=0xFF80; add r15,r15,r15 -> r15=0xFF00; DBG_ADDR=15 returns 0xFF00.

Source files
------------

// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised two-state (FETCH/EXEC) CPU core with a
// request/acknowledge instruction fetch, an internal instruction register,
// a resettable register file and a combinational debug read port.
// Optional feature macro: CPU_BRANCH_EN builds j (0x06) and beq (0x07);
// without it both opcodes decode as undefined.
module cpu_core_param #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3,
    parameter int PC_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [PC_W-1:0]   PC,
    output logic              IMEM_REQ,
    input  logic              IMEM_ACK,
    input  logic [31:0]       INSTRUCTION,
    output logic              ZERO,
    output logic              ILLEGAL,
    input  logic [REG_AW-1:0] DBG_ADDR,
    output logic [DATA_W-1:0] DBG_DATA
);

    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
`ifdef CPU_BRANCH_EN
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
`endif

    typedef enum logic {FETCH, EXEC} state_t;

    state_t            state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Decoded fields of the instruction register.
    logic [7:0]        opcode;
    logic [REG_AW-1:0] rd_idx;
    logic [REG_AW-1:0] rs1_idx;
    logic [REG_AW-1:0] rs2_idx;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm_sext;
    logic [PC_W-1:0]   pc_plus4;

    // Decode results consumed on the EXEC->FETCH edge.
    logic              wr_en;
    logic              zero_upd;
    logic              illegal_op;
    logic [DATA_W-1:0] wr_data;
    logic [PC_W-1:0]   next_pc;

    // Not every IR bit is used in every configuration (narrow REG_AW, no branches).
    logic              unused_ir;

    assign opcode    = ir[31:24];
    assign rd_idx    = ir[16 +: REG_AW];
    assign rs1_idx   = ir[8 +: REG_AW];
    assign rs2_idx   = ir[0 +: REG_AW];
    assign rs1_val   = regs[rs1_idx];
    assign rs2_val   = regs[rs2_idx];
    assign imm_sext  = DATA_W'($signed(ir[7:0]));
    assign pc_plus4  = PC + PC_W'(4);
    assign unused_ir = ^ir;

`ifdef CPU_BRANCH_EN
    logic [PC_W-1:0] br_target;

    // Word offset relative to the following instruction; wraps modulo 2^PC_W.
    assign br_target = pc_plus4 + (PC_W'($signed(ir[23:16])) << 2);
`endif

    // Fetch is requested whenever the core waits in FETCH and is out of reset.
    assign IMEM_REQ = (state == FETCH) && RESET;

    // Debug port reads the register file with no added latency.
    assign DBG_DATA = regs[DBG_ADDR];

    // Decode IR and compute write-back data, flag updates and the next PC.
    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that left one unassigned would infer a latch.
        wr_en      = 1'b0;
        zero_upd   = 1'b0;
        illegal_op = 1'b0;
        wr_data    = '0;
        next_pc    = pc_plus4;
        case (opcode)
            OP_LOADI: begin
                wr_en   = 1'b1;
                wr_data = imm_sext;
            end
            OP_MOV: begin
                wr_en   = 1'b1;
                wr_data = rs2_val;
            end
            OP_ADD: begin
                wr_en    = 1'b1;
                zero_upd = 1'b1;
                wr_data  = rs1_val + rs2_val;
            end
            OP_SUB: begin
                wr_en    = 1'b1;
                zero_upd = 1'b1;
                wr_data  = rs1_val - rs2_val;
            end
            OP_AND: begin
                wr_en    = 1'b1;
                zero_upd = 1'b1;
                wr_data  = rs1_val & rs2_val;
            end
            OP_OR: begin
                wr_en    = 1'b1;
                zero_upd = 1'b1;
                wr_data  = rs1_val | rs2_val;
            end
`ifdef CPU_BRANCH_EN
            OP_J: begin
                next_pc = br_target;
            end
            OP_BEQ: begin
                if (rs1_val == rs2_val) begin
                    next_pc = br_target;
                end
            end
`endif
            default: begin
                illegal_op = 1'b1;
            end
        endcase
    end

    // FSM, PC, IR, register file and flags; reset overrides any fetch or commit in progress.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
            state   <= FETCH;
            PC      <= '0;
            ir      <= '0;
            ZERO    <= 1'b0;
            ILLEGAL <= 1'b0;
            // NOTE: the register file must read 0 after reset, so each entry is cleared explicitly; this also keeps it in flops rather than RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[REG_AW'(i)] <= '0;
            end
        end else begin
            ILLEGAL <= 1'b0;
            case (state)
                FETCH: begin
                    if (IMEM_ACK) begin
                        ir    <= INSTRUCTION;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (wr_en) begin
                        regs[rd_idx] <= wr_data;
                    end
                    if (zero_upd) begin
                        ZERO <= (wr_data == '0);
                    end
                    ILLEGAL <= illegal_op;
                    PC      <= next_pc;
                    state   <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param: a directed vector table, hand-written
// multi-cycle sequences (stall, illegal, branch, reset during EXEC, width) and
// a randomized run checked against an instruction-level reference model.
module tb_cpu_core_param;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IMEM_ACK;
    logic [31:0] INSTRUCTION;
    logic [2:0]  DBG_ADDR;
    logic [31:0] PC;
    logic        IMEM_REQ;
    logic        ZERO;
    logic        ILLEGAL;
    logic [7:0]  DBG_DATA;

    // Wide instance: same instruction stream, 16-bit data, 16 registers.
    logic [3:0]  w_dbg_addr;
    logic [31:0] w_pc;
    logic        w_req;
    logic        w_zero;
    logic        w_ill;
    logic [15:0] w_dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (architectural view only).
    logic [7:0]  mregs [8];
    logic [31:0] mpc;
    logic        mzero;
    logic        mill;

    typedef struct {
        logic [31:0] instr;
        int          stall;
        logic [2:0]  reg_sel;
        logic [7:0]  reg_val;
        logic [31:0] pc;
        logic        zero;
        logic        ill;
    } vec_t;

    vec_t vecs [11];

    cpu_core_param dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (PC),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ACK    (IMEM_ACK),
        .INSTRUCTION (INSTRUCTION),
        .ZERO        (ZERO),
        .ILLEGAL     (ILLEGAL),
        .DBG_ADDR    (DBG_ADDR),
        .DBG_DATA    (DBG_DATA)
    );

    cpu_core_param #(.DATA_W(16), .REG_AW(4), .PC_W(32)) dut_w (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC          (w_pc),
        .IMEM_REQ    (w_req),
        .IMEM_ACK    (IMEM_ACK),
        .INSTRUCTION (INSTRUCTION),
        .ZERO        (w_zero),
        .ILLEGAL     (w_ill),
        .DBG_ADDR    (w_dbg_addr),
        .DBG_DATA    (w_dbg_data)
    );

    always #10 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mpc   = 32'd0;
        mzero = 1'b0;
        mill  = 1'b0;
    endtask

    // Architectural effect of one instruction, straight from the opcode table.
    task automatic model_exec(input logic [31:0] ins);
        logic [7:0]         op;
        logic [7:0]         a;
        logic [7:0]         b;
        logic [7:0]         r;
        logic [2:0]         rd;
        logic [31:0]        nxt;
        logic signed [31:0] off;
        op   = ins[31:24];
        rd   = ins[18:16];
        a    = mregs[ins[10:8]];
        b    = mregs[ins[2:0]];
        off  = $signed(ins[23:16]);
        nxt  = mpc + 32'd4;
        mill = 1'b0;
        case (op)
            8'h00: mregs[rd] = ins[7:0];
            8'h01: mregs[rd] = b;
            8'h02, 8'h03, 8'h04, 8'h05: begin
                if (op == 8'h02)      r = a + b;
                else if (op == 8'h03) r = a - b;
                else if (op == 8'h04) r = a & b;
                else                  r = a | b;
                mregs[rd] = r;
                mzero     = (r == 8'h00);
            end
`ifdef CPU_BRANCH_EN
            8'h06: nxt = nxt + 32'(off * 4);
            8'h07: if (a == b) nxt = nxt + 32'(off * 4);
`endif
            default: mill = 1'b1;
        endcase
        mpc = nxt;
    endtask

    task automatic check_all(input string tag, input logic exp_req);
        check({tag, "_pc"}, PC, mpc);
        check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, mzero});
        check({tag, "_ill"}, {31'd0, ILLEGAL}, {31'd0, mill});
        check({tag, "_req"}, {31'd0, IMEM_REQ}, {31'd0, exp_req});
        for (int i = 0; i < 8; i++) begin
            DBG_ADDR = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), {24'd0, DBG_DATA}, {24'd0, mregs[i]});
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (3) begin
            IMEM_ACK    = 1'($urandom_range(0, 1));
            INSTRUCTION = $urandom;
            step();
        end
        model_reset();
        check_all("reset", 1'b0);
        RESET    = 1'b1;
        IMEM_ACK = 1'b0;
        #1;
        check("release_req", {31'd0, IMEM_REQ}, 32'd1);
    endtask

    // One complete fetch (with optional stall) and commit, then a full state compare.
    task automatic run_instr(input logic [31:0] instr, input int stall);
        INSTRUCTION = instr;
        IMEM_ACK    = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            check("stall_req", {31'd0, IMEM_REQ}, 32'd1);
            check("stall_pc", PC, mpc);
            check("stall_ill", {31'd0, ILLEGAL}, 32'd0);
        end
        IMEM_ACK = 1'b1;
        step();
        check("exec_req", {31'd0, IMEM_REQ}, 32'd0);
        check("exec_pc", PC, mpc);
        check("exec_ill", {31'd0, ILLEGAL}, 32'd0);
        IMEM_ACK    = 1'($urandom_range(0, 1));
        INSTRUCTION = $urandom;
        step();
        IMEM_ACK = 1'b0;
        model_exec(instr);
        check_all("commit", 1'b1);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [7:0]  op;
        int          sel;

        RESET       = 1'b0;
        IMEM_ACK    = 1'b0;
        INSTRUCTION = 32'd0;
        DBG_ADDR    = 3'd0;
        w_dbg_addr  = 4'd15;
        model_reset();

        vecs[0]  = '{32'h0004_0005, 0, 3'd4, 8'h05, 32'd4,  1'b0, 1'b0}; // loadi r4,5
        vecs[1]  = '{32'h0002_0009, 0, 3'd2, 8'h09, 32'd8,  1'b0, 1'b0}; // loadi r2,9
        vecs[2]  = '{32'h0206_0402, 5, 3'd6, 8'h0E, 32'd12, 1'b0, 1'b0}; // add r6,r4,r2 (stall 5)
        vecs[3]  = '{32'h0305_0604, 0, 3'd5, 8'h09, 32'd16, 1'b0, 1'b0}; // sub r5,r6,r4
        vecs[4]  = '{32'h0407_0402, 0, 3'd7, 8'h01, 32'd20, 1'b0, 1'b0}; // and r7,r4,r2
        vecs[5]  = '{32'h0303_0202, 0, 3'd3, 8'h00, 32'd24, 1'b1, 1'b0}; // sub r3,r2,r2
        vecs[6]  = '{32'h0001_0080, 0, 3'd1, 8'h80, 32'd28, 1'b1, 1'b0}; // loadi r1,0x80
        vecs[7]  = '{32'h0500_0104, 0, 3'd0, 8'h85, 32'd32, 1'b0, 1'b0}; // or r0,r1,r4
        vecs[8]  = '{32'h0102_0003, 2, 3'd2, 8'h00, 32'd36, 1'b0, 1'b0}; // mov r2,r3
        vecs[9]  = '{32'hFF01_0101, 0, 3'd1, 8'h80, 32'd40, 1'b0, 1'b1}; // undefined opcode
        vecs[10] = '{32'h0201_0101, 1, 3'd1, 8'h00, 32'd44, 1'b1, 1'b0}; // add r1,r1,r1 (carry out)

        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_instr(vecs[i].instr, vecs[i].stall);
            DBG_ADDR = vecs[i].reg_sel;
            #1;
            check($sformatf("vec%0d_reg", i), {24'd0, DBG_DATA}, {24'd0, vecs[i].reg_val});
            check($sformatf("vec%0d_pc", i), PC, vecs[i].pc);
            check($sformatf("vec%0d_zero", i), {31'd0, ZERO}, {31'd0, vecs[i].zero});
            check($sformatf("vec%0d_ill", i), {31'd0, ILLEGAL}, {31'd0, vecs[i].ill});
        end

        // Undefined opcode at PC=4, then a stalled fetch while the pulse must be gone.
        do_reset();
        run_instr(32'h0001_0003, 0);
        run_instr(32'hFF01_0007, 0);
        DBG_ADDR = 3'd1;
        #1;
        check("ill_pc", PC, 32'd8);
        check("ill_pulse", {31'd0, ILLEGAL}, 32'd1);
        check("ill_r1", {24'd0, DBG_DATA}, 32'h03);
        run_instr(32'h0002_0009, 3);

        // Branches.
        do_reset();
        run_instr(32'h0001_0003, 0);
        run_instr(32'h0002_0003, 0);
        run_instr(32'h0702_0102, 0);
`ifdef CPU_BRANCH_EN
        check("beq_pc", PC, 32'd20);
        run_instr(32'h06FD_0000, 0);
        check("j_pc", PC, 32'd12);
        run_instr(32'h0303_0102, 0);
        DBG_ADDR = 3'd3;
        #1;
        check("br_r3", {24'd0, DBG_DATA}, 32'd0);
        check("br_zero", {31'd0, ZERO}, 32'd1);
        check("br_pc", PC, 32'd16);
`else
        check("beq_undef_pc", PC, 32'd12);
        check("beq_undef_ill", {31'd0, ILLEGAL}, 32'd1);
        run_instr(32'h0601_0000, 0);
        check("j_undef_pc", PC, 32'd16);
        check("j_undef_ill", {31'd0, ILLEGAL}, 32'd1);
`endif

        // Reset asserted during EXEC of add r6: nothing commits.
        do_reset();
        run_instr(32'h0004_0005, 0);
        run_instr(32'h0002_0009, 0);
        INSTRUCTION = 32'h0206_0402;
        IMEM_ACK    = 1'b1;
        step();
        check("rx_exec_req", {31'd0, IMEM_REQ}, 32'd0);
        RESET    = 1'b0;
        IMEM_ACK = 1'b0;
        step();
        model_reset();
        check_all("rx", 1'b0);
        RESET = 1'b1;
        #1;
        check("rx_release_req", {31'd0, IMEM_REQ}, 32'd1);

        // Width: 16-bit instance sign-extends and wraps at 16 bits.
        do_reset();
        run_instr(32'h000F_0080, 0);
        check("w_loadi", {16'd0, w_dbg_data}, 32'hFF80);
        run_instr(32'h020F_0F0F, 1);
        check("w_add", {16'd0, w_dbg_data}, 32'hFF00);
        check("w_zero", {31'd0, w_zero}, 32'd0);
        check("w_pc", w_pc, 32'd8);
        check("w_req", {31'd0, w_req}, 32'd1);
        check("w_ill", {31'd0, w_ill}, 32'd0);

        // Randomized instruction stream against the reference model.
        do_reset();
        repeat (200) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 8) ? 8'(sel) : 8'($urandom_range(8, 255));
            rnd = $urandom;
            run_instr({op, rnd[23:0]}, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
